// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU command sequencer: FSM states and ALU unit-select codes.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } seq_state_t;

    localparam logic [1:0] UNIT_ARI = 2'b00;
    localparam logic [1:0] UNIT_LOG = 2'b01;
    localparam logic [1:0] UNIT_CMP = 2'b10;
    localparam logic [1:0] UNIT_SHF = 2'b11;

    // The two opcode MSBs pick which ALU unit's result is meaningful.
    function automatic logic [1:0] unit_of(input logic [3:0] fun);
        return fun[3:2];
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_cmd_seq: DEPTH entries of WIDTH bits, power-of-two pointers that wrap.
// push_ready is registered so it reads 0 while reset is held and 1 from the first edge after release.
module alu_cmd_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             ready_q;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push_valid && ready_q;
    assign do_pop     = pop && (count != '0);
    assign push_ready = ready_q;
    assign empty      = (count == '0);
    assign pop_data   = mem[rd_ptr];

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_next;
            ready_q <= (count_next != CNT_FULL);
        end
    end

    // NOTE: the storage array is not reset; an entry is only ever read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: queues commands, issues them to an external ALU and returns results in order.
// Optional completed-operation counter enabled by defining ALU_CMD_SEQ_OPCNT_EN.
module alu_cmd_seq
    import alu_seq_pkg::*;
#(
    parameter int WID   = 16,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rest,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_fun,
    input  logic [WID-1:0] cmd_a,
    input  logic [WID-1:0] cmd_b,
    output logic [3:0]     alu_fun,
    output logic [WID-1:0] alu_a,
    output logic [WID-1:0] alu_b,
    input  logic [WID-1:0] ari_out,
    input  logic [WID-1:0] log_out,
    input  logic [WID-1:0] cmp_out,
    input  logic [WID-1:0] shift_out,
    input  logic           carry_out,
    input  logic           ari_flag,
    input  logic           log_flag,
    input  logic           cmp_flag,
    input  logic           shift_flag,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [WID-1:0] res_data,
    output logic           res_flag,
    output logic           res_carry,
    output logic [3:0]     res_fun,
    output logic           busy,
    output logic [15:0]    op_count
);

    localparam int CMD_W = 2 * WID + 4;

    seq_state_t     state;
    seq_state_t     state_next;
    logic           pop;
    logic           capture;
    logic           fifo_empty;
    logic [CMD_W-1:0] head;
    logic [WID-1:0] sel_data;
    logic           sel_flag;
    logic           sel_carry;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rest       (rest),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  ({cmd_fun, cmd_a, cmd_b}),
        .pop        (pop),
        .pop_data   (head),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        res_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                capture    = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Carry is only meaningful from the arithmetic unit.
    always_comb begin
        sel_data  = ari_out;
        sel_flag  = ari_flag;
        sel_carry = 1'b0;
        unique case (unit_of(alu_fun))
            UNIT_ARI: begin
                sel_data  = ari_out;
                sel_flag  = ari_flag;
                sel_carry = carry_out;
            end
            UNIT_LOG: begin
                sel_data = log_out;
                sel_flag = log_flag;
            end
            UNIT_CMP: begin
                sel_data = cmp_out;
                sel_flag = cmp_flag;
            end
            UNIT_SHF: begin
                sel_data = shift_out;
                sel_flag = shift_flag;
            end
            default: ;
        endcase
    end

    // ALU drive registers only change on a pop, so they hold the last issued command otherwise.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            alu_fun <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (pop) begin
            alu_fun <= head[CMD_W-1 -: 4];
            alu_a   <= head[2*WID-1 -: WID];
            alu_b   <= head[WID-1:0];
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            res_data  <= '0;
            res_flag  <= 1'b0;
            res_carry <= 1'b0;
            res_fun   <= '0;
        end else if (capture) begin
            res_data  <= sel_data;
            res_flag  <= sel_flag;
            res_carry <= sel_carry;
            res_fun   <= alu_fun;
        end
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

`ifdef ALU_CMD_SEQ_OPCNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest)                       op_cnt_q <= '0;
        else if (res_valid && res_ready) op_cnt_q <= op_cnt_q + 16'd1;
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Self-checking bench for alu_cmd_seq: directed commands feed a scoreboard queue that a
// separate monitor drains and compares whenever a result is presented.
module tb_alu_cmd_seq;

    localparam int WID   = 16;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rest;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_fun;
    logic [WID-1:0] cmd_a;
    logic [WID-1:0] cmd_b;
    logic [3:0]     alu_fun;
    logic [WID-1:0] alu_a;
    logic [WID-1:0] alu_b;
    logic [WID-1:0] ari_out;
    logic [WID-1:0] log_out;
    logic [WID-1:0] cmp_out;
    logic [WID-1:0] shift_out;
    logic           carry_out;
    logic           ari_flag;
    logic           log_flag;
    logic           cmp_flag;
    logic           shift_flag;
    logic           res_valid;
    logic           res_ready;
    logic [WID-1:0] res_data;
    logic           res_flag;
    logic           res_carry;
    logic [3:0]     res_fun;
    logic           busy;
    logic [15:0]    op_count;

    alu_cmd_seq #(.WID(WID), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rest       (rest),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_fun    (cmd_fun),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_fun    (alu_fun),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .ari_out    (ari_out),
        .log_out    (log_out),
        .cmp_out    (cmp_out),
        .shift_out  (shift_out),
        .carry_out  (carry_out),
        .ari_flag   (ari_flag),
        .log_flag   (log_flag),
        .cmp_flag   (cmp_flag),
        .shift_flag (shift_flag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .res_carry  (res_carry),
        .res_fun    (res_fun),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    // Stub ALU with fixed, registered results; flags differ per unit so a wrong select shows up.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            ari_out <= '0; log_out <= '0; cmp_out <= '0; shift_out <= '0;
            carry_out <= 1'b0; ari_flag <= 1'b0; log_flag <= 1'b0;
            cmp_flag <= 1'b0; shift_flag <= 1'b0;
        end else begin
            ari_out <= 16'h1111; log_out <= 16'h2222; cmp_out <= 16'h3333; shift_out <= 16'h4444;
            carry_out <= 1'b1; ari_flag <= 1'b0; log_flag <= 1'b1;
            cmp_flag <= 1'b0; shift_flag <= 1'b1;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        flag;
        logic        carry;
        logic [3:0]  fun;
    } exp_t;

    exp_t        exp_q[$];
    int          rise_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          exp_ops  = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] unit_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic        unit_flag [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t expect_for(input logic [3:0] fun);
        exp_t e;
        logic [1:0] u;
        u       = fun[3:2];
        e.data  = unit_data[u];
        e.flag  = unit_flag[u];
        e.carry = (u == 2'b00);
        e.fun   = fun;
        return e;
    endfunction

    function automatic logic [15:0] want_ops();
`ifdef ALU_CMD_SEQ_OPCNT_EN
        return exp_ops[15:0];
`else
        return 16'd0;
`endif
    endfunction

    // Monitor: every cycle a result is shown it must match the queue head; pop on handshake.
    always @(negedge clk) begin
        if (rest && res_valid) begin
            if (!prev_valid) rise_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_res_valid got=%h expected=none (t=%0t)", res_data, $time);
            end else begin
                check("res_data",  32'(res_data),  32'(exp_q[0].data));
                check("res_flag",  32'(res_flag),  32'(exp_q[0].flag));
                check("res_carry", 32'(res_carry), 32'(exp_q[0].carry));
                check("res_fun",   32'(res_fun),   32'(exp_q[0].fun));
                if (res_ready) begin
                    check("op_count_at_handshake", 32'(op_count), 32'(want_ops()));
                    void'(exp_q.pop_front());
                    exp_ops++;
                end
            end
        end
        prev_valid = rest && res_valid;
    end

    // Offer one command; it is scoreboarded at the edge where it is accepted.
    task automatic send(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
        int budget;
        budget = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_fun   = fun;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout got=cmd_ready_low expected=accept fun=%h", fun);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(expect_for(fun));
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 res_ready = v;
    endtask

    initial begin
        rest      = 1'b0;
        cmd_valid = 1'b0;
        cmd_fun   = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b1;

        // Reset state
        #23;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_alu_a",     32'(alu_a),     32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        @(negedge clk);
        rest = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single arithmetic command: issue and result latency
        send(4'b0000, 16'h0003, 16'h0004);
        @(posedge clk); #1;
        check("issue_alu_a",   32'(alu_a),   32'h0003);
        check("issue_alu_b",   32'(alu_b),   32'h0004);
        check("issue_alu_fun", 32'(alu_fun), 32'h0);
        check("lat_edge1_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge2_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_edge3_valid", 32'(res_valid), 32'd1);
        wait_drain();
        check("hold_alu_a", 32'(alu_a), 32'h0003);

        // Logic/compare/shift back-to-back: order and 4-cycle spacing
        rise_q.delete();
        send(4'b0100, 16'h0010, 16'h0020);
        send(4'b1000, 16'h0030, 16'h0040);
        send(4'b1100, 16'h0050, 16'h0060);
        wait_drain();
        check("tput_results", 32'(rise_q.size()), 32'd3);
        if (rise_q.size() == 3) begin
            check("tput_gap0", 32'(rise_q[1] - rise_q[0]), 32'd4);
            check("tput_gap1", 32'(rise_q[2] - rise_q[1]), 32'd4);
        end

        // Stall with res_ready low: FIFO fills, results held, drain in order
        set_ready(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) send(4'(i * 5), 16'(16'h0100 + i), 16'(i));
        check("full_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (5) @(negedge clk);
        check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        check("stall_res_valid", 32'(res_valid), 32'd1);
        set_ready(1'b1);
        wait_drain();

        // Full FIFO while head pops, then 3*DEPTH commands through the wrapping pointers
        set_ready(1'b0);
        for (int i = 0; i < DEPTH + 1; i++) send(4'(15 - i), 16'(16'h0200 + i), 16'h00ff);
        check("full2_cmd_ready", 32'(cmd_ready), 32'd0);
        set_ready(1'b1);
        send(4'b0110, 16'h0abc, 16'h0def);
        for (int i = 0; i < 3 * DEPTH; i++) send(4'(i * 7), 16'(16'h0300 + i), 16'(i * 3));
        wait_drain();

        // Asynchronous reset during WAIT with a further command queued
        send(4'b1001, 16'h0aaa, 16'h0bbb);
        send(4'b0011, 16'h0ccc, 16'h0ddd);
        @(posedge clk); #1;
        #1 rest = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_alu_a",     32'(alu_a),     32'd0);
        check("mid_rst_alu_fun",   32'(alu_fun),   32'd0);
        check("mid_rst_res_data",  32'(res_data),  32'd0);
        check("mid_rst_res_carry", 32'(res_carry), 32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_op_count",  32'(op_count),  32'd0);
        exp_q.delete();
        exp_ops = 0;
        @(negedge clk);
        rest = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_idle_busy",  32'(busy),      32'd0);
        check("post_rst_idle_valid", 32'(res_valid), 32'd0);

        // Five completed operations for the operation counter
        for (int i = 0; i < 5; i++) send(4'(i * 3), 16'(i), 16'(i + 1));
        wait_drain();
        @(negedge clk);
`ifdef ALU_CMD_SEQ_OPCNT_EN
        check("op_count_final", 32'(op_count), 32'd5);
`else
        check("op_count_final", 32'(op_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter WID, default 16, operand/result width (matches ALU width).
REQ-002 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rest  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_fun / cmd_a / cmd_b  in  4 / WID / WID  opcode and operands.
REQ-008 alu_fun / alu_a / alu_b  out  4 / WID / WID  registered drive to ALU.
REQ-009 ari_out, log_out, cmp_out, shift_out  in  WID each  ALU unit results.
REQ-010 carry_out, ari_flag, log_flag, cmp_flag, shift_flag  in  1 each  ALU unit flags.
REQ-011 res_valid  out  1  result available; res_ready  in  1  result consumed.
REQ-012 res_data / res_flag / res_carry / res_fun  out  WID / 1 / 1 / 4  captured result, flag, carry, opcode.
REQ-013 busy  out  1  high when state != IDLE or FIFO non-empty.
REQ-014 op_count  out  16  completed-operation count (see Configuration).

Function
REQ-015 Command FIFO SHALL push on cmd_valid&&cmd_ready; cmd_ready SHALL equal !full; no push when full.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE with FIFO non-empty: pop head, load alu_fun/alu_a/alu_b at edge, go ISSUE; IDLE with FIFO empty: stay.
REQ-018 ISSUE SHALL last exactly one cycle (ALU registers inputs) then go WAIT.
REQ-019 WAIT SHALL last one cycle; at its closing edge capture selected unit result into res_* and go RESP.
REQ-020 Unit select by alu_fun[3:2]: 00 arithmetic (ari_out, ari_flag, carry_out), 01 logic, 10 compare, 11 shift; res_carry SHALL be 0 for non-arithmetic units.
REQ-021 res_valid SHALL be high exactly in RESP; res_* SHALL hold stable until res_valid&&res_ready, then go IDLE.
REQ-022 Latency: pop edge to res_valid rising = 3 edges; max throughput one operation per 4 cycles with res_ready held high.
REQ-023 alu_a/alu_b/alu_fun SHALL hold last issued values outside issue.
REQ-024 Push and pop in same cycle SHALL both occur; FIFO count unchanged; a push into empty FIFO is poppable no earlier than next cycle.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH without losing or duplicating entries.
REQ-026 Commands SHALL complete in acceptance order.

Reset
REQ-027 rest low SHALL asynchronously force IDLE, empty FIFO, all outputs 0 (cmd_ready=1 after release), op_count=0.
REQ-028 Reset mid-operation SHALL discard in-flight and queued commands; no res_valid after release until a new command completes.

Configuration
REQ-029 Macro ALU_CMD_SEQ_OPCNT_EN defined: op_count SHALL increment (wrapping at 0xFFFF) on each res_valid&&res_ready.
REQ-030 Macro undefined: op_count SHALL be constant 0, counter logic absent; port list unchanged.

Structure
REQ-031 Package alu_seq_pkg SHALL hold FSM state encoding and unit-select constants (UNIT_ARI=2'b00, UNIT_LOG=2'b01, UNIT_CMP=2'b10, UNIT_SHF=2'b11).
REQ-032 FIFO SHALL be sub-module alu_cmd_fifo (WID*2+4 bits wide, DEPTH deep).

Verification (stub ALU: ari_out=0x1111, log_out=0x2222, cmp_out=0x3333, shift_out=0x4444, carry_out=1, registered one cycle)
REQ-033 Push fun=4'b0000 a=0x0003 b=0x0004 -> alu_a=0x0003 one edge after pop, res_valid 3 edges after pop, res_data=0x1111, res_carry=1, res_fun=0.
REQ-034 Push fun 4'b0100, 4'b1000, 4'b1100 back-to-back, res_ready=1 -> results 0x2222, 0x3333, 0x4444 in order, res_carry=0, 4 cycles apart.
REQ-035 res_ready=0, push DEPTH+1 commands -> cmd_ready low after FIFO fills; res_* stable while stalled; all drain in order after res_ready=1.
REQ-036 Push while FIFO full and head popping same cycle -> no push accepted that cycle; next cycle accepted; pointer wrap exercised over 3*DEPTH commands.
REQ-037 Assert rest low during WAIT -> all outputs 0 immediately; after release no res_valid until new command.
REQ-038 With ALU_CMD_SEQ_OPCNT_EN: 5 completed operations -> op_count=5; without macro op_count=0 throughout.
